// File: rtl/keccak_sched_pkg.sv
// Shared types and constants for the two-client keccak core scheduler.
package keccak_sched_pkg;

    localparam int unsigned RATE_BITS     = 1088;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORDS_PER_BLK = 34;
    localparam int unsigned WCNT_W        = 6;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        ABSORB,
        PAD,
        WAIT,
        DRAIN,
        SQZ,
        DONE
    } state_t;

endpackage

// File: rtl/keccak_sched_rr.sv
// Two-way round-robin arbiter; on a tie the client that did not own the last job wins.
module keccak_sched_rr
    import keccak_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant_c
);

    logic last_owner;

    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_owner ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= 1'b1;
        end else if (take && (req != 2'b00)) begin
            last_owner <= grant_c[1];
        end
    end

endmodule

// File: rtl/keccak_sched.sv
// Shares one keccak core between two hash clients: grant, core reset, absorb with
// final-word tagging, then squeeze and serialise the requested rate blocks.
module keccak_sched
    import keccak_sched_pkg::*;
#(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned NB_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [2*LEN_W-1:0]    req_len,
    input  logic [2*NB_W-1:0]     req_nblk,
    output logic [1:0]            req_grant,
    input  logic [1:0]            din_valid,
    input  logic [63:0]           din_data,
    output logic [1:0]            din_ready,
    output logic                  dout_valid,
    output logic [31:0]           dout_data,
    output logic                  dout_last,
    input  logic                  dout_ready,
    output logic                  kc_reset,
    output logic [31:0]           kc_in,
    output logic                  kc_in_ready,
    output logic                  kc_is_last,
    output logic [1:0]            kc_byte_num,
    input  logic                  kc_buffer_full,
    output logic                  kc_squeeze,
    input  logic [RATE_BITS-1:0]  kc_out,
    input  logic                  kc_out_ready
);

    state_t                state;
    logic                  owner;
    logic [LEN_W-1:0]      rem;
    logic [NB_W-1:0]       nblk_q;
    logic [NB_W-1:0]       blk_cnt;
    logic [WCNT_W-1:0]     word_cnt;
    logic [RATE_BITS-1:0]  shreg;
    logic [1:0]            arb_grant_c;
    logic                  arb_take_c;

    logic                  absorb_rdy_c;
    logic                  xfer_c;
    logic                  final_c;
    logic                  pad_c;
    logic [WORD_W-1:0]     owner_word_c;
    logic [LEN_W-1:0]      win_len_c;
    logic [NB_W-1:0]       win_nblk_c;
    logic                  last_word_c;
    logic                  last_blk_c;

    assign arb_take_c = (state == IDLE);

    keccak_sched_rr u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .take    (arb_take_c),
        .grant_c (arb_grant_c)
    );

    assign win_len_c  = arb_grant_c[1] ? req_len[2*LEN_W-1 -: LEN_W] : req_len[LEN_W-1:0];
    assign win_nblk_c = arb_grant_c[1] ? req_nblk[2*NB_W-1 -: NB_W] : req_nblk[NB_W-1:0];

    // Absorb handshake is a combinational pass-through from the owner to the core.
    assign absorb_rdy_c = (state == ABSORB) && (rem != '0) && !kc_buffer_full;
    assign xfer_c       = absorb_rdy_c && din_valid[owner];
    assign final_c      = (rem <= LEN_W'(3));
    assign pad_c        = (state == PAD) && !kc_buffer_full;
    assign owner_word_c = owner ? din_data[63:32] : din_data[31:0];

    assign din_ready   = absorb_rdy_c ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign kc_in_ready = xfer_c || pad_c;
    assign kc_in       = xfer_c ? owner_word_c : '0;
    assign kc_is_last  = (xfer_c && final_c) || pad_c;
    assign kc_byte_num = (xfer_c && final_c) ? rem[1:0] : 2'b00;

    assign last_word_c = (word_cnt == WCNT_W'(WORDS_PER_BLK - 1));
    assign last_blk_c  = (blk_cnt == (nblk_q - NB_W'(1)));
    assign dout_data   = shreg[RATE_BITS-1 -: WORD_W];
    assign dout_last   = dout_valid && last_word_c && last_blk_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rem        <= '0;
            nblk_q     <= '0;
            blk_cnt    <= '0;
            word_cnt   <= '0;
            shreg      <= '0;
            req_grant  <= 2'b00;
            dout_valid <= 1'b0;
            kc_reset   <= 1'b0;
            kc_squeeze <= 1'b0;
        end else begin
            kc_reset   <= 1'b0;
            kc_squeeze <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_grant_c != 2'b00) begin
                        owner     <= arb_grant_c[1];
                        rem       <= win_len_c;
                        nblk_q    <= (win_nblk_c == '0) ? NB_W'(1) : win_nblk_c;
                        blk_cnt   <= '0;
                        req_grant <= arb_grant_c;
                        kc_reset  <= 1'b1;
                        state     <= RST;
                    end
                end
                RST: state <= ABSORB;
                ABSORB: begin
                    // A length that is a multiple of 4 ends in an explicit zero-byte final word.
                    if (rem == '0) begin
                        state <= PAD;
                    end else if (xfer_c) begin
                        if (final_c) begin
                            rem   <= '0;
                            state <= WAIT;
                        end else begin
                            rem <= rem - LEN_W'(4);
                        end
                    end
                end
                PAD: begin
                    if (!kc_buffer_full) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (kc_out_ready) begin
                        shreg      <= kc_out;
                        word_cnt   <= '0;
                        dout_valid <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dout_ready) begin
                        shreg    <= shreg << WORD_W;
                        word_cnt <= word_cnt + WCNT_W'(1);
                        if (last_word_c) begin
                            dout_valid <= 1'b0;
                            if (last_blk_c) begin
                                req_grant <= 2'b00;
                                state     <= DONE;
                            end else begin
                                blk_cnt    <= blk_cnt + NB_W'(1);
                                kc_squeeze <= 1'b1;
                                state      <= SQZ;
                            end
                        end
                    end
                end
                SQZ:     state <= WAIT;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/keccak_sched.md
Name: keccak_sched

Overview:
- Round-robin scheduler sharing one keccak core between two hash clients, for example seed expansion and message hashing in the NewHope datapath.
- Per job it does four things:
  - grants one client;
  - resets the core;
  - streams that client's message words into the core, generating is_last/byte_num;
  - squeezes the requested number of 1088-bit rate blocks, serialising each as 34 32-bit words back to the owning client.

Parameters:
LEN_W, 16, width of message length in bytes
NB_W, 8, width of output block count

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  2  per-client job request, held until grant
req_len  in  2*LEN_W  per-client message length in bytes; client i at [i*LEN_W +: LEN_W]
req_nblk  in  2*NB_W  per-client output block count; 0 is treated as 1
req_grant  out  2  one-hot, high for the whole job of the owner
din_valid  in  2  per-client message word valid
din_data  in  64  per-client word; client i at [32*i +: 32]; first byte in [31:24]
din_ready  out  2  word accepted when din_valid[i] & din_ready[i]
dout_valid  out  1  output word valid, for the owner
dout_data  out  32  output word
dout_last  out  1  last word of the last block of the job
dout_ready  in  1  owner accepts output word
kc_reset  out  1  synchronous reset pulse to keccak core
kc_in  out  32  word to core
kc_in_ready  out  1  word strobe to core
kc_is_last  out  1  final-word flag to core
kc_byte_num  out  2  valid bytes in final word
kc_buffer_full  in  1  core cannot accept a word
kc_squeeze  out  1  request next output block
kc_out  in  1088  core rate output; word 0 = [1087:1056]
kc_out_ready  in  1  core output valid

Behaviour:
- Reset (async): state IDLE, last_owner=1. All outputs 0, including req_grant, din_ready, dout_valid, kc_reset, kc_in_ready, kc_squeeze.
- IDLE: sample req_valid.
  - If one client requests, grant it.
  - If both request, grant the client != last_owner.
  - On grant, latch len and nblk (0 -> 1), set req_grant, update last_owner, go to RST.
  - Transition takes 1 cycle.
- RST: kc_reset=1 for exactly 1 cycle, then ABSORB. The core state flag is sticky, so every job starts with this pulse.
- ABSORB:
  - din_ready[owner] = ~kc_buffer_full. The other din_ready bit stays 0.
  - On each transfer: kc_in_ready=1 and kc_in=din_data[owner], in the same cycle (combinational pass-through), and the remaining byte count decrements by 4.
  - The final transfer (remaining <= 3, nonzero) asserts kc_is_last=1 with kc_byte_num=remaining. It then goes to WAIT.
  - If remaining == 0 (length a multiple of 4, including len=0), go to PAD without taking further words.
- PAD: when ~kc_buffer_full, one cycle of kc_in_ready=1, kc_is_last=1, kc_byte_num=0, kc_in=0. Then WAIT.
- kc_is_last is never asserted without kc_in_ready.
- WAIT: wait for kc_out_ready=1. Latch kc_out into a 1088-bit shift register, set word_cnt=0, go to DRAIN.
- DRAIN:
  - dout_valid=1 and dout_data = top word of the shift register.
  - On dout_valid & dout_ready: shift left by 32, word_cnt++.
  - dout_last=1 on word 33 of the final block.
  - After word 33: if blocks remain, go to SQZ; otherwise go to DONE.
- SQZ: kc_squeeze=1 for 1 cycle, blk_cnt++, then WAIT. Waiting on kc_out_ready high from the previous block is impossible, because the core clears it on squeeze.
- DONE: deassert req_grant, 1 cycle, back to IDLE. A client holding req_valid is eligible again, and loses to a waiting other client.
- req_valid dropping mid-job is ignored; the job runs to completion.
- dout_ready stalls hold dout_data stable.
- din_valid gaps insert idle cycles only.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RST, ABSORB, PAD, WAIT, DRAIN, SQZ, DONE);
  - RATE_BITS=1088;
  - WORDS_PER_BLK=34.
- One sub-module, keccak_sched_rr: a 2-way round-robin arbiter with a last_owner register, producing the one-hot grant.
- The shift register and counters stay in the top level.

Test Plan:
- Client 0, len=3, nblk=1, word 0x61626300:
  - one transfer with kc_is_last=1, kc_byte_num=3;
  - no PAD;
  - 34 dout words, dout_last only on word 33.
- Client 1, len=8, nblk=2:
  - two words, then PAD with is_last=1, byte_num=0, kc_in=0;
  - one kc_squeeze pulse after word 33 of block 0;
  - 68 output words total.
- len=0:
  - no din_ready on any cycle;
  - single PAD word;
  - output equals the SHA3-256 empty-message digest in the first 8 words.
- Both req_valid rise the same cycle after reset:
  - client 0 is granted first (last_owner=1);
  - client 1 is granted after DONE;
  - if client 0 immediately requests again, client 1 still wins.
- kc_buffer_full held high 5 cycles mid-ABSORB, and dout_ready low 3 cycles mid-DRAIN:
  - no transfers occur and no word is lost or duplicated;
  - dout_data stays stable.
- reset asserted in DRAIN:
  - all outputs go to 0 immediately (async);
  - state is IDLE;
  - the next request is granted and preceded by a kc_reset pulse.
